datapath: RTL and testbench

- 32-bit single-bus datapath for the Mini SRC CPU, driven entirely by an external control unit or testbench.
- Contains the register file R0–R15, PC, IR, Y, 64-bit Z, HI, LO, MAR, MDR, In/Out port registers, CON flip-flop, the ALU, select/encode logic and a 512x32 RAM.
- Instruction fields: opcode IR[31:27], Ra IR[26:23], Rb IR[22:19], Rc IR[18:15], C IR[18:0].

---
 rtl/datapath.sv | 233 +++++++++++++++++++++++
 tb/tb_datapath.sv | 177 +++++++++++++++++
 2 files changed

// File: rtl/datapath.sv
// Mini SRC 32-bit single-bus datapath: register file, special registers, ALU,
// select/encode logic and a word-addressed RAM, sequenced by an external controller.
module datapath #(
  parameter int unsigned MEM_DEPTH     = 512,
  parameter string       MEM_INIT_FILE = ""
) (
  input  logic        clock,
  input  logic        clear,
  input  logic        incPC,
  input  logic        e_PC,
  input  logic        e_IR,
  input  logic        e_Y,
  input  logic        e_Z,
  input  logic        e_HI,
  input  logic        e_LO,
  input  logic        e_MAR,
  input  logic        e_MDR,
  input  logic        e_OutPort,
  input  logic        e_InPort,
  input  logic        e_GP,
  input  logic        e_RA,
  input  logic        e_CON_FF,
  input  logic        ram_read,
  input  logic        ram_write,
  output logic [31:0] Mdatain,
  input  logic        MDR_read,
  input  logic [3:0]  ALU_op,
  input  logic [4:0]  BusDataSelect,
  input  logic        Gra,
  input  logic        Grb,
  input  logic        Grc,
  input  logic        e_Rin,
  input  logic        e_Rout,
  input  logic        BAout,
  input  logic        imm_sel
);

  localparam int unsigned W    = 32;
  localparam int unsigned NREG = 16;
  localparam int unsigned RW   = 4;
  localparam int unsigned CW   = 19;
  localparam int unsigned AW   = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;

  localparam logic [3:0] OP_AND  = 4'b0000;
  localparam logic [3:0] OP_OR   = 4'b0001;
  localparam logic [3:0] OP_SUB  = 4'b0010;
  localparam logic [3:0] OP_ADD  = 4'b0011;
  localparam logic [3:0] OP_SHR  = 4'b0100;
  localparam logic [3:0] OP_SHRA = 4'b0101;
  localparam logic [3:0] OP_SHL  = 4'b0110;
  localparam logic [3:0] OP_ROR  = 4'b0111;
  localparam logic [3:0] OP_ROL  = 4'b1000;
  localparam logic [3:0] OP_MUL  = 4'b1001;
  localparam logic [3:0] OP_DIV  = 4'b1010;
  localparam logic [3:0] OP_NEG  = 4'b1011;
  localparam logic [3:0] OP_NOT  = 4'b1100;

  // Architectural state (names kept short for hierarchical access)
  logic [W-1:0]   R [NREG];
  logic [W-1:0]   PC, IR, Y, HI, LO, MAR, MDR, OutPort, InPort;
  logic [2*W-1:0] Z;
  logic           CON;
  logic [W-1:0]   mem [MEM_DEPTH];

  logic [RW-1:0]  w_ra, w_rb, w_rc, w_idx;
  logic           w_gr_any, w_reg_out;
  logic [W-1:0]   w_c_sext, w_bus, w_b;
  logic [4:0]     w_sh;
  logic [2*W-1:0] w_ya, w_ba, w_prod, w_dbl, w_ror64, w_rol64, w_alu;
  logic [W-1:0]   w_sra, w_quo, w_rem;
  logic           w_con;
  logic [AW-1:0]  w_addr;
  logic [W-AW+5+W-1:0] w_unused_bits;

  // IR field decode
  assign w_ra     = IR[26:23];
  assign w_rb     = IR[22:19];
  assign w_rc     = IR[18:15];
  assign w_c_sext = {{(W-CW){IR[CW-1]}}, IR[CW-1:0]};
  assign w_addr   = MAR[AW-1:0];

  assign w_unused_bits = {IR[31:27], MAR[W-1:AW], OutPort};

  // Register select/encode, Gra > Grb > Grc
  always_comb begin
    w_idx = w_rc;
    if (Gra)      w_idx = w_ra;
    else if (Grb) w_idx = w_rb;
  end

  assign w_gr_any  = Gra | Grb | Grc;
  assign w_reg_out = (e_Rout | BAout) & w_gr_any;

  // Bus source mux; a selected register output overrides BusDataSelect
  always_comb begin
    w_bus = '0;
    if (w_reg_out) begin
      w_bus = (BAout && (w_idx == RW'(0))) ? '0 : R[w_idx];
    end else if (!BusDataSelect[4]) begin
      w_bus = R[BusDataSelect[3:0]];
    end else begin
      case (BusDataSelect)
        5'd16:   w_bus = HI;
        5'd17:   w_bus = LO;
        5'd18:   w_bus = Z[2*W-1:W];
        5'd19:   w_bus = Z[W-1:0];
        5'd20:   w_bus = PC;
        5'd21:   w_bus = MDR;
        5'd22:   w_bus = InPort;
        5'd23:   w_bus = w_c_sext;
        default: w_bus = '0;
      endcase
    end
  end

  // ALU operand prep
  assign w_b     = imm_sel ? w_c_sext : w_bus;
  assign w_sh    = w_b[4:0];
  assign w_ya    = {{W{Y[W-1]}}, Y};
  assign w_ba    = {{W{w_b[W-1]}}, w_b};
  assign w_prod  = w_ya * w_ba;
  assign w_dbl   = {Y, Y};
  assign w_ror64 = w_dbl >> w_sh;
  assign w_rol64 = w_dbl << w_sh;
  assign w_sra   = $signed(Y) >>> w_sh;

  // Signed divide; zero divisor and the single overflow case handled explicitly
  always_comb begin
    w_quo = '0;
    w_rem = '0;
    if (w_b == '0) begin
      w_quo = '0;
      w_rem = '0;
    end else if ((Y == 32'h8000_0000) && (w_b == 32'hFFFF_FFFF)) begin
      w_quo = Y;
      w_rem = '0;
    end else begin
      w_quo = W'($signed(Y) / $signed(w_b));
      w_rem = W'($signed(Y) % $signed(w_b));
    end
  end

  always_comb begin
    w_alu = '0;
    case (ALU_op)
      OP_AND:  w_alu = {{W{1'b0}}, Y & w_b};
      OP_OR:   w_alu = {{W{1'b0}}, Y | w_b};
      OP_SUB:  w_alu = {{W{1'b0}}, W'(Y - w_b)};
      OP_ADD:  w_alu = {{W{1'b0}}, W'(Y + w_b)};
      OP_SHR:  w_alu = {{W{1'b0}}, Y >> w_sh};
      OP_SHRA: w_alu = {{W{1'b0}}, w_sra};
      OP_SHL:  w_alu = {{W{1'b0}}, Y << w_sh};
      OP_ROR:  w_alu = {{W{1'b0}}, w_ror64[W-1:0]};
      OP_ROL:  w_alu = {{W{1'b0}}, w_rol64[2*W-1:W]};
      OP_MUL:  w_alu = w_prod;
      OP_DIV:  w_alu = {w_rem, w_quo};
      OP_NEG:  w_alu = {{W{1'b0}}, W'(-w_b)};
      OP_NOT:  w_alu = {{W{1'b0}}, ~w_b};
      default: w_alu = {{W{1'b0}}, w_b};
    endcase
  end

  // Branch condition chosen by IR[20:19]
  always_comb begin
    w_con = 1'b0;
    case (IR[20:19])
      2'b00:   w_con = (w_bus == '0);
      2'b01:   w_con = (w_bus != '0);
      2'b10:   w_con = ~w_bus[W-1];
      default: w_con = w_bus[W-1];
    endcase
  end

  // General-purpose register file
  always_ff @(posedge clock) begin
    for (int unsigned i = 0; i < NREG; i++) begin
      if (clear) begin
        R[i] <= '0;
      end else if ((e_Rin && w_gr_any && (w_idx == RW'(i))) ||
                   (e_GP && (w_ra == RW'(i))) ||
                   (e_RA && (i == NREG - 1))) begin
        R[i] <= w_bus;
      end
    end
  end

  // Special-purpose registers
  always_ff @(posedge clock) begin
    if (clear) begin
      PC      <= '0;
      IR      <= '0;
      Y       <= '0;
      Z       <= '0;
      HI      <= '0;
      LO      <= '0;
      MAR     <= '0;
      MDR     <= '0;
      OutPort <= '0;
      InPort  <= '0;
      CON     <= 1'b0;
    end else begin
      if (incPC)          PC <= PC + W'(1);
      else if (e_PC)      PC <= w_bus;
      if (e_IR)      IR      <= w_bus;
      if (e_Y)       Y       <= w_bus;
      if (e_Z)       Z       <= w_alu;
      if (e_HI)      HI      <= w_bus;
      if (e_LO)      LO      <= w_bus;
      if (e_MAR)     MAR     <= w_bus;
      if (e_MDR)     MDR     <= MDR_read ? Mdatain : w_bus;
      if (e_OutPort) OutPort <= w_bus;
      if (e_InPort)  InPort  <= w_bus;
      if (e_CON_FF)  CON     <= w_con;
    end
  end

  // RAM image starts at zero
  initial begin
    for (int unsigned i = 0; i < MEM_DEPTH; i++) mem[i] = '0;
  end

  // RAM write port; contents survive clear
  always_ff @(posedge clock) begin
    if (!clear && ram_write) mem[w_addr] <= MDR;
  end

  // Registered read port; a simultaneous write returns the old word
  always_ff @(posedge clock) begin
    if (clear)         Mdatain <= '0;
    else if (ram_read) Mdatain <= mem[w_addr];
  end

endmodule

// File: tb/tb_datapath.sv
// Directed bench for datapath: fetch/execute sequences, RAM, ALU and priority checks.
module tb_datapath;

  logic        clock = 1'b0;
  logic        clear, incPC;
  logic        e_PC, e_IR, e_Y, e_Z, e_HI, e_LO, e_MAR, e_MDR, e_OutPort, e_InPort;
  logic        e_GP, e_RA, e_CON_FF, ram_read, ram_write, MDR_read;
  logic [31:0] Mdatain;
  logic [3:0]  ALU_op;
  logic [4:0]  BusDataSelect;
  logic        Gra, Grb, Grc, e_Rin, e_Rout, BAout, imm_sel;

  int n_assert = 0;
  int n_fail   = 0;

  datapath #(.MEM_DEPTH(512), .MEM_INIT_FILE("")) dut (
    .clock(clock), .clear(clear), .incPC(incPC),
    .e_PC(e_PC), .e_IR(e_IR), .e_Y(e_Y), .e_Z(e_Z), .e_HI(e_HI), .e_LO(e_LO),
    .e_MAR(e_MAR), .e_MDR(e_MDR), .e_OutPort(e_OutPort), .e_InPort(e_InPort),
    .e_GP(e_GP), .e_RA(e_RA), .e_CON_FF(e_CON_FF),
    .ram_read(ram_read), .ram_write(ram_write), .Mdatain(Mdatain),
    .MDR_read(MDR_read), .ALU_op(ALU_op), .BusDataSelect(BusDataSelect),
    .Gra(Gra), .Grb(Grb), .Grc(Grc), .e_Rin(e_Rin), .e_Rout(e_Rout),
    .BAout(BAout), .imm_sel(imm_sel)
  );

  always #5 clock = ~clock;

  task automatic idle();
    clear = 0; incPC = 0; e_PC = 0; e_IR = 0; e_Y = 0; e_Z = 0; e_HI = 0; e_LO = 0;
    e_MAR = 0; e_MDR = 0; e_OutPort = 0; e_InPort = 0; e_GP = 0; e_RA = 0;
    e_CON_FF = 0; ram_read = 0; ram_write = 0; MDR_read = 0; ALU_op = 4'd0;
    BusDataSelect = 5'd0; Gra = 0; Grb = 0; Grc = 0; e_Rin = 0; e_Rout = 0;
    BAout = 0; imm_sel = 0;
  endtask

  // Apply the currently driven controls for one edge, then return to idle
  task automatic tick();
    @(posedge clock);
    #1;
    idle();
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Fetch the word at PC into IR via MAR/Mdatain/MDR
  task automatic fetch();
    BusDataSelect = 5'd20; e_MAR = 1;    tick();
    ram_read = 1;                        tick();
    MDR_read = 1; e_MDR = 1;             tick();
    BusDataSelect = 5'd21; e_IR = 1;     tick();
  endtask

  initial begin
    idle();
    clear = 1; incPC = 1; e_MAR = 1; BusDataSelect = 5'd20; e_Rin = 1; Gra = 1;
    #2;
    dut.mem[0] <= 32'h4300_000A;
    dut.mem[1] <= 32'h42B7_FFF9;
    dut.mem[3] <= 32'hDEAD_BEEF;
    @(posedge clock); @(posedge clock); #1;
    check("reset_PC",   dut.PC,   64'h0);
    check("reset_MAR",  dut.MAR,  64'h0);
    check("reset_R6",   dut.R[6], 64'h0);
    check("reset_Z",    dut.Z,    64'h0);
    check("reset_CON",  dut.CON,  64'h0);
    check("reset_Mdin", Mdatain,  64'h0);
    idle();

    // ldi R6,0x0A
    fetch();
    check("ldi_IR", dut.IR, 64'h4300_000A);
    Grb = 1; BAout = 1; e_Y = 1;                 tick();
    check("ldi_Y_base0", dut.Y, 64'h0);
    imm_sel = 1; ALU_op = 4'd3; e_Z = 1;         tick();
    BusDataSelect = 5'd19; Gra = 1; e_Rin = 1;   tick();
    check("ldi_R6", dut.R[6], 64'h0000_000A);

    // ori R5,R6,-7
    incPC = 1;                                   tick();
    check("inc_PC", dut.PC, 64'h1);
    fetch();
    check("ori_IR", dut.IR, 64'h42B7_FFF9);
    Grb = 1; e_Rout = 1; e_Y = 1;                tick();
    imm_sel = 1; ALU_op = 4'd1; e_Z = 1;         tick();
    BusDataSelect = 5'd19; Gra = 1; e_Rin = 1;   tick();
    check("ori_R5", dut.R[5], 64'hFFFF_FFFB);
    check("ori_R6", dut.R[6], 64'h0000_000A);

    // CON: IR[20:19]=10 selects >=0
    BusDataSelect = 5'd5; e_CON_FF = 1;          tick();
    check("con_neg", dut.CON, 64'h0);
    BusDataSelect = 5'd6; e_CON_FF = 1;          tick();
    check("con_pos", dut.CON, 64'h1);

    // RAM: MDR <= mem[3], store at mem[5], read back
    imm_sel = 1; ALU_op = 4'd3; e_Z = 1;         tick();
    BusDataSelect = 5'd19; e_MAR = 1; e_RA = 1;  tick();
    check("ra_R15", dut.R[15], 64'h3);
    ram_read = 1;                                tick();
    MDR_read = 1; e_MDR = 1;                     tick();
    check("mdr_load", dut.MDR, 64'hDEAD_BEEF);
    BusDataSelect = 5'd20; ALU_op = 4'd4; e_Z = 1; tick();
    BusDataSelect = 5'd19; e_MAR = 1;            tick();
    check("mar_5", dut.MAR, 64'h5);
    ram_write = 1;                               tick();
    BusDataSelect = 5'd0; e_MDR = 1;             tick();
    check("mdr_bus0", dut.MDR, 64'h0);
    ram_read = 1; ram_write = 1;                 tick();
    check("rw_old_word", Mdatain, 64'hDEAD_BEEF);
    MDR_read = 1; e_MDR = 1;                     tick();
    check("mdr_readback", dut.MDR, 64'hDEAD_BEEF);
    ram_read = 1;                                tick();
    check("rw_new_word", Mdatain, 64'h0);

    // MUL -2 * 3
    BusDataSelect = 5'd20; ALU_op = 4'd12; e_Z = 1; tick();
    BusDataSelect = 5'd19; e_Y = 1;              tick();
    BusDataSelect = 5'd15; ALU_op = 4'd9; e_Z = 1; tick();
    check("mul", dut.Z, 64'hFFFF_FFFF_FFFF_FFFA);

    // DIV 7/2, 7/-7, 7/0
    BusDataSelect = 5'd15; e_Y = 1;              tick();
    BusDataSelect = 5'd20; ALU_op = 4'd2; e_Z = 1; tick();
    BusDataSelect = 5'd19; e_GP = 1;             tick();
    check("gp_R5", dut.R[5], 64'h2);
    BusDataSelect = 5'd6; e_Y = 1;               tick();
    BusDataSelect = 5'd15; ALU_op = 4'd2; e_Z = 1; tick();
    BusDataSelect = 5'd19; e_Y = 1;              tick();
    check("sub_Y7", dut.Y, 64'h7);
    BusDataSelect = 5'd5; ALU_op = 4'd10; e_Z = 1; tick();
    check("div_7_2", dut.Z, 64'h0000_0001_0000_0003);
    imm_sel = 1; ALU_op = 4'd10; e_Z = 1;        tick();
    check("div_7_m7", dut.Z, 64'h0000_0000_FFFF_FFFF);
    BusDataSelect = 5'd0; ALU_op = 4'd10; e_Z = 1; tick();
    check("div_by0", dut.Z, 64'h0);

    // Rotates and misc bus sources
    BusDataSelect = 5'd5; ALU_op = 4'd8; e_Z = 1;  tick();
    check("rol", dut.Z, 64'h1C);
    BusDataSelect = 5'd20; ALU_op = 4'd7; e_Z = 1; tick();
    check("ror", dut.Z, 64'h8000_0003);
    BusDataSelect = 5'd23; e_HI = 1;             tick();
    check("hi_sextC", dut.HI, 64'hFFFF_FFF9);
    BusDataSelect = 5'd16; e_LO = 1;             tick();
    check("lo_from_hi", dut.LO, 64'hFFFF_FFF9);
    Grb = 1; BAout = 1; e_Y = 1;                 tick();
    check("baout_R6", dut.Y, 64'hA);

    // PC priority and wrap
    BusDataSelect = 5'd6; incPC = 1; e_PC = 1;   tick();
    check("pc_inc_prio", dut.PC, 64'h2);
    BusDataSelect = 5'd6; e_PC = 1;              tick();
    check("pc_load", dut.PC, 64'hA);
    BusDataSelect = 5'd0; ALU_op = 4'd12; e_Z = 1; tick();
    BusDataSelect = 5'd19; e_PC = 1;             tick();
    incPC = 1;                                   tick();
    check("pc_wrap", dut.PC, 64'h0);

    // clear beats e_Rin; RAM survives clear
    clear = 1; Gra = 1; e_Rin = 1; BusDataSelect = 5'd6; tick();
    check("clear_R5", dut.R[5], 64'h0);
    check("clear_R6", dut.R[6], 64'h0);
    ram_read = 1;                                tick();
    check("ram_kept", Mdatain, 64'h4300_000A);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
